// File: rtl/sfp_link_ctrl.sv
// SFP link sequencer: orders laser, LVDS driver and receiver enables, debounces
// LOSS_SIG / TX_FLT and gates the encode/decode datapath until the link is up.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// OFF       | everything inactive, waiting for i_enable
// PWRUP     | LVDS driver/receiver on, laser still disabled, fixed dwell
// TX_ON     | laser on, settling before the encoder starts
// LINK_WAIT | encoder transmitting, waiting for light and decoder lock
// LINKED    | link confirmed, decoded data released to OUT
// FAULT     | laser held off for the retry interval, then re-sequence
module sfp_link_ctrl #(
  parameter int unsigned STARTUP_CYC = 400,
  parameter int unsigned TXON_CYC    = 4000,
  parameter int unsigned RETRY_CYC   = 40000,
  parameter int unsigned FILT_CYC    = 16
) (
  input  logic       i_clk,
  input  logic       i_res_n,
  input  logic       i_enable,
  input  logic       i_sfp_loss_sig,
  input  logic       i_sfp_tx_flt,
  input  logic       i_rx_locked,
  output logic       o_sfp_tx_dis_n,
  output logic       o_lvds_drv_en,
  output logic       o_lvds_rcv_en_n,
  output logic       o_tx_active,
  output logic       o_rx_valid,
  output logic [2:0] o_state,
  output logic [7:0] o_fault_cnt
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_PWRUP     = 3'd1,
    S_TX_ON     = 3'd2,
    S_LINK_WAIT = 3'd3,
    S_LINKED    = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYC - 1);
  localparam logic [15:0] TXON_LAST    = 16'(TXON_CYC - 1);
  localparam logic [15:0] RETRY_LAST   = 16'(RETRY_CYC - 1);
  localparam logic [7:0]  FILT_LAST    = 8'(FILT_CYC - 1);

  logic        los_s1, los_s2, flt_s1, flt_s2;
  logic        los_f, flt_f;
  logic [7:0]  los_cnt, flt_cnt;
  state_t      state, state_nxt;
  logic [15:0] timer;
  logic        tx_dis_n_q, drv_en_q, rcv_en_n_q, tx_active_q, rx_valid_q;
  logic [7:0]  fault_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      los_s1 <= 1'b0;
      los_s2 <= 1'b0;
      flt_s1 <= 1'b0;
      flt_s2 <= 1'b0;
    end else begin
      los_s1 <= i_sfp_loss_sig;
      los_s2 <= los_s1;
      flt_s1 <= i_sfp_tx_flt;
      flt_s2 <= flt_s1;
    end
  end

  // A debounced flag only follows the synced pin after FILT_CYC disagreeing
  // cycles in a row; a single agreeing cycle restarts the run.
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      los_f   <= 1'b1;
      los_cnt <= 8'd0;
    end else if (los_s2 != los_f) begin
      if (los_cnt == FILT_LAST) begin
        los_f   <= los_s2;
        los_cnt <= 8'd0;
      end else begin
        los_cnt <= los_cnt + 8'd1;
      end
    end else begin
      los_cnt <= 8'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      flt_f   <= 1'b0;
      flt_cnt <= 8'd0;
    end else if (flt_s2 != flt_f) begin
      if (flt_cnt == FILT_LAST) begin
        flt_f   <= flt_s2;
        flt_cnt <= 8'd0;
      end else begin
        flt_cnt <= flt_cnt + 8'd1;
      end
    end else begin
      flt_cnt <= 8'd0;
    end
  end

  // Output pattern per state: {tx_dis_n, drv_en, rcv_en_n, tx_active, rx_valid}
  function automatic logic [4:0] out_decode(input state_t st);
    logic [4:0] o;
    o = 5'b00100;
    case (st)
      S_PWRUP:     o = 5'b01000;
      S_TX_ON:     o = 5'b11000;
      S_LINK_WAIT: o = 5'b11010;
      S_LINKED:    o = 5'b11011;
      S_FAULT:     o = 5'b01000;
      default:     o = 5'b00100;
    endcase
    return o;
  endfunction

  always_comb begin
    state_nxt = state;
    if (!i_enable) begin
      state_nxt = S_OFF;
    end else begin
      case (state)
        S_OFF:       state_nxt = S_PWRUP;
        S_PWRUP:     if (timer == STARTUP_LAST) state_nxt = S_TX_ON;
        S_TX_ON: begin
          if (flt_f)                   state_nxt = S_FAULT;
          else if (timer == TXON_LAST) state_nxt = S_LINK_WAIT;
        end
        S_LINK_WAIT: begin
          if (flt_f)                          state_nxt = S_FAULT;
          else if (!los_f && i_rx_locked)     state_nxt = S_LINKED;
        end
        S_LINKED: begin
          if (flt_f)                          state_nxt = S_FAULT;
          else if (los_f || !i_rx_locked)     state_nxt = S_LINK_WAIT;
        end
        S_FAULT:     if (timer == RETRY_LAST) state_nxt = S_PWRUP;
        default:     state_nxt = S_OFF;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state       <= S_OFF;
      timer       <= 16'd0;
      fault_cnt_q <= 8'd0;
      {tx_dis_n_q, drv_en_q, rcv_en_n_q, tx_active_q, rx_valid_q} <= 5'b00100;
    end else begin
      state <= state_nxt;
      timer <= (state_nxt != state) ? 16'd0 : timer + 16'd1;
      if (state_nxt == S_FAULT && state != S_FAULT && fault_cnt_q != 8'hFF)
        fault_cnt_q <= fault_cnt_q + 8'd1;
      {tx_dis_n_q, drv_en_q, rcv_en_n_q, tx_active_q, rx_valid_q} <= out_decode(state_nxt);
    end
  end

  assign o_sfp_tx_dis_n  = tx_dis_n_q;
  assign o_lvds_drv_en   = drv_en_q;
  assign o_lvds_rcv_en_n = rcv_en_n_q;
  assign o_tx_active     = tx_active_q;
  assign o_rx_valid      = rx_valid_q;
  assign o_state         = state;
  assign o_fault_cnt     = fault_cnt_q;

endmodule

// File: tb/tb_sfp_link_ctrl.sv
// Bench for sfp_link_ctrl: directed test-plan scenarios plus random pin activity,
// every cycle compared against a behavioural model of the link sequencing rules.
module tb_sfp_link_ctrl;

  localparam int STARTUP = 8;
  localparam int TXON    = 16;
  localparam int RETRY   = 32;
  localparam int FILT    = 4;

  logic       clk;
  logic       res_n, en, los, flt, locked;
  logic       tx_dis_n, drv_en, rcv_en_n, tx_active, rx_valid;
  logic [2:0] state;
  logic [7:0] fault_cnt;
  logic [4:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  sfp_link_ctrl #(
    .STARTUP_CYC(STARTUP), .TXON_CYC(TXON), .RETRY_CYC(RETRY), .FILT_CYC(FILT)
  ) dut (
    .i_clk(clk), .i_res_n(res_n), .i_enable(en),
    .i_sfp_loss_sig(los), .i_sfp_tx_flt(flt), .i_rx_locked(locked),
    .o_sfp_tx_dis_n(tx_dis_n), .o_lvds_drv_en(drv_en), .o_lvds_rcv_en_n(rcv_en_n),
    .o_tx_active(tx_active), .o_rx_valid(rx_valid),
    .o_state(state), .o_fault_cnt(fault_cnt)
  );

  assign outs = {tx_dis_n, drv_en, rcv_en_n, tx_active, rx_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state, m_dwell, m_fcnt;
  bit m_los_f, m_flt_f;
  bit los_dl[$], flt_dl[$], los_win[$], flt_win[$];

  function automatic int exp_outs(input int st);
    case (st)
      1: return 5'b01000;
      2: return 5'b11000;
      3: return 5'b11010;
      4: return 5'b11011;
      5: return 5'b01000;
      default: return 5'b00100;
    endcase
  endfunction

  function automatic bit all_equal(input bit q[$], input bit v);
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_dwell = 0; m_fcnt = 0;
    m_los_f = 1'b1; m_flt_f = 1'b0;
    los_dl = '{1'b0, 1'b0}; flt_dl = '{1'b0, 1'b0};
    los_win.delete(); flt_win.delete();
  endtask

  task automatic model_edge();
    int nxt;
    bit seen;
    if (!res_n) begin
      model_reset();
      return;
    end
    nxt = m_state;
    if (!en) nxt = 0;
    else begin
      case (m_state)
        0: nxt = 1;
        1: if (m_dwell + 1 >= STARTUP) nxt = 2;
        2: if (m_flt_f) nxt = 5; else if (m_dwell + 1 >= TXON) nxt = 3;
        3: if (m_flt_f) nxt = 5; else if (!m_los_f && locked) nxt = 4;
        4: if (m_flt_f) nxt = 5; else if (m_los_f || !locked) nxt = 3;
        5: if (m_dwell + 1 >= RETRY) nxt = 1;
        default: nxt = 0;
      endcase
    end
    if (nxt == 5 && m_state != 5 && m_fcnt < 255) m_fcnt++;
    m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
    m_state = nxt;
    // pins reach the filter two edges late; flag flips once the last FILT views all disagree
    seen = los_dl.pop_front(); los_dl.push_back(los);
    los_win.push_back(seen); if (los_win.size() > FILT) void'(los_win.pop_front());
    if (los_win.size() == FILT && all_equal(los_win, !m_los_f)) m_los_f = !m_los_f;
    seen = flt_dl.pop_front(); flt_dl.push_back(flt);
    flt_win.push_back(seen); if (flt_win.size() > FILT) void'(flt_win.pop_front());
    if (flt_win.size() == FILT && all_equal(flt_win, !m_flt_f)) m_flt_f = !m_flt_f;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("state", state, m_state);
    chk("outs", outs, exp_outs(m_state));
    chk("fault_cnt", fault_cnt, m_fcnt);
  endtask

  task automatic wait_state(input int code, input int max_edges, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (state != code && n < max_edges);
    if (state != code) chk("timeout_state", state, code);
  endtask

  int n, cnt;

  initial begin
    res_n = 1'b0; en = 1'b0; los = 1'b0; flt = 1'b0; locked = 1'b1;
    model_reset();
    step();
    chk("reset_state", state, 0);
    chk("reset_outs", outs, 5'b00100);
    chk("reset_fcnt", fault_cnt, 0);
    res_n = 1'b1;
    repeat (8) step();

    // nominal bring-up
    en = 1'b1;
    wait_state(4, 100, n);
    chk("bringup_edges", n, 26);
    chk("bringup_rx_valid", rx_valid, 1);

    // LOS glitch shorter than filter, then a real loss and recovery
    los = 1'b1; repeat (3) step();
    los = 1'b0; repeat (12) step();
    chk("los_glitch_state", state, 4);
    los = 1'b1;
    wait_state(3, 50, n);
    chk("los_drop_edges", n, 7);
    chk("los_drop_rx_valid", rx_valid, 0);
    los = 1'b0;
    wait_state(4, 50, n);
    chk("los_back_edges", n, 7);

    // TX fault recovery
    flt = 1'b1;
    wait_state(5, 50, n);
    chk("flt_entry_edges", n, 7);
    cnt = 1;
    for (int i = 0; i < 100 && state == 5; i++) begin
      if (i == 3) flt = 1'b0;
      step();
      if (state == 5) cnt++;
    end
    flt = 1'b0;
    chk("fault_dwell", cnt, 32);
    chk("fault_cnt_1", fault_cnt, 1);
    chk("after_fault_state", state, 1);
    wait_state(4, 100, n);
    chk("resequence_edges", n, 25);

    // disable mid TX_ON, then clean re-sequence
    en = 1'b0; step();
    chk("disable_linked", state, 0);
    en = 1'b1;
    wait_state(2, 50, n);
    repeat (5) step();
    en = 1'b0; step();
    chk("disable_state", state, 0);
    chk("disable_outs", outs, 5'b00100);
    en = 1'b1;
    wait_state(3, 100, n);
    chk("reenable_edges", n, 25);

    // random pin activity against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) en = !en;
      if ($urandom_range(19) == 0) los = !los;
      if (flt ? ($urandom_range(14) == 0) : ($urandom_range(149) == 0)) flt = !flt;
      if ($urandom_range(29) == 0) locked = !locked;
      res_n = ($urandom_range(799) != 0);
      step();
    end

    // persistent fault: 1-cycle laser pulses, counter saturates
    res_n = 1'b1; en = 1'b1; los = 1'b0; locked = 1'b1; flt = 1'b1;
    wait_state(2, 200, n);
    chk("pulse_on", tx_dis_n, 1);
    step();
    chk("pulse_off_state", state, 5);
    chk("pulse_off_laser", tx_dis_n, 0);
    repeat (255 * 41 + 100) step();
    chk("fault_cnt_sat", fault_cnt, 255);
    repeat (100) step();
    chk("fault_cnt_hold", fault_cnt, 255);

    // reset in LINKED
    flt = 1'b0;
    wait_state(4, 300, n);
    chk("linked_before_reset", state, 4);
    res_n = 1'b0; step();
    chk("rst_state", state, 0);
    chk("rst_outs", outs, 5'b00100);
    chk("rst_fcnt", fault_cnt, 0);
    res_n = 1'b1;
    wait_state(4, 100, n);
    chk("rebuild_edges", n, 26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
